// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port DataMEM between the pipeline MEM stage (port 0) and
// a debug/loader port (port 1). One access is performed per clock. Port 0
// has priority, but a starvation counter hands the memory to port 1 once
// port 0 has won P0_MAX_BURST consecutive contended cycles. Read data is
// registered back to the port that issued the read.
//
// Optional feature: define DMEM_ARB_STATS_EN to add the access/wait
// statistics counters (Cnt0, Cnt1, Cnt_wait1) and the Stats_clr input.
//
// Ports:
//   Clk, Rst_n                  clock (rising edge), async active-low reset
//   Req0/We0/Addr0/Wd0          port 0 request, write enable, address, data
//   Gnt0, Stall0                port 0 grant (combinational), stall request
//   Rvalid0, Rd0                port 0 registered read valid pulse and data
//   Req1/We1/Addr1/Wd1          port 1 request, write enable, address, data
//   Gnt1, Rvalid1, Rd1          port 1 grant, read valid pulse and data
//   Mem_WE/Mem_RE/Mem_A/Mem_WD  DataMEM control, address, write data
//   Mem_RD                      DataMEM combinational read data
//   Last_grant                  status: 00 IDLE, 01 SERVE0, 10 SERVE1
//   Stats_clr, Cnt0, Cnt1, Cnt_wait1   (DMEM_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int P0_MAX_BURST = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Req0,
    input  logic          We0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] Wd0,
    output logic          Gnt0,
    output logic          Stall0,
    output logic          Rvalid0,
    output logic [DW-1:0] Rd0,
    input  logic          Req1,
    input  logic          We1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] Wd1,
    output logic          Gnt1,
    output logic          Rvalid1,
    output logic [DW-1:0] Rd1,
    output logic          Mem_WE,
    output logic          Mem_RE,
    output logic [AW-1:0] Mem_A,
    output logic [DW-1:0] Mem_WD,
    input  logic [DW-1:0] Mem_RD,
    output logic [1:0]    Last_grant
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic          Stats_clr,
    output logic [15:0]   Cnt0,
    output logic [15:0]   Cnt1,
    output logic [15:0]   Cnt_wait1
`endif
);

    localparam logic [3:0] MaxBurst = 4'(P0_MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic            rvalid0_q, rvalid1_q;
    logic [DW-1:0]   rd0_q, rd1_q;
    logic            p1Turn;
    logic            rdGnt0, rdGnt1;

    // Port 1 wins when it is alone or once port 0 has used up its burst
    // allowance. Both grants are gated by Rst_n so nothing reaches the
    // memory while reset is held, whatever the requesters are doing.
    assign p1Turn = Req1 & (~Req0 | (starve_q == MaxBurst));
    assign Gnt1   = Rst_n & p1Turn;
    assign Gnt0   = Rst_n & Req0 & ~p1Turn;
    assign Stall0 = Req0 & ~Gnt0;

    assign rdGnt0 = Gnt0 & ~We0;
    assign rdGnt1 = Gnt1 & ~We1;

    // Memory-side mux: the granted port drives DataMEM, otherwise all zero.
    always_comb begin
        Mem_WE = 1'b0;
        Mem_RE = 1'b0;
        Mem_A  = '0;
        Mem_WD = '0;
        if (Gnt1) begin
            Mem_WE = We1;
            Mem_RE = ~We1;
            Mem_A  = Addr1;
            Mem_WD = Wd1;
        end else if (Gnt0) begin
            Mem_WE = We0;
            Mem_RE = ~We0;
            Mem_A  = Addr0;
            Mem_WD = Wd0;
        end
    end

    // Starvation counter: counts contended cycles port 1 lost to port 0,
    // saturating at the burst limit; cleared once port 1 is served or leaves.
    always_comb begin
        starve_d = starve_q;
        if (Gnt1 || !Req1) begin
            starve_d = '0;
        end else if (Gnt0 && (starve_q != MaxBurst)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Status FSM next state: follows whichever port was granted this cycle.
    always_comb begin
        state_d = IDLE;
        if (Gnt0) begin
            state_d = SERVE0;
        end else if (Gnt1) begin
            state_d = SERVE1;
        end
    end

    // State, counter and read-return registers. Read data is captured only
    // on that port's own granted read so it holds until the port reads again.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rvalid0_q <= rdGnt0;
            rvalid1_q <= rdGnt1;
            if (rdGnt0) begin
                rd0_q <= Mem_RD;
            end
            if (rdGnt1) begin
                rd1_q <= Mem_RD;
            end
        end
    end

    assign Rvalid0    = rvalid0_q;
    assign Rvalid1    = rvalid1_q;
    assign Rd0        = rd0_q;
    assign Rd1        = rd1_q;
    assign Last_grant = state_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q, cntWait1_q;

    // Saturating statistics; a synchronous clear beats any increment.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            cntWait1_q <= '0;
        end else if (Stats_clr) begin
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            cntWait1_q <= '0;
        end else begin
            if (Gnt0 && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (Gnt1 && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
            if (Req1 && !Gnt1 && (cntWait1_q != 16'hFFFF)) begin
                cntWait1_q <= cntWait1_q + 16'd1;
            end
        end
    end

    assign Cnt0      = cnt0_q;
    assign Cnt1      = cnt1_q;
    assign Cnt_wait1 = cntWait1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed and randomized bench for dmem_arbiter. The bench plays the part of
// DataMEM (memArr, written from the DUT's memory outputs) and keeps its own
// reference model: a reference memory, a count of consecutive cycles port 1
// has been refused, and the expected read-return values per port.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW           = 8;
    localparam int DW           = 8;
    localparam int P0_MAX_BURST = 4;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Req0, We0, Req1, We1;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] Wd0, Wd1;
    logic          Gnt0, Gnt1, Stall0, Rvalid0, Rvalid1;
    logic [DW-1:0] Rd0, Rd1;
    logic          Mem_WE, Mem_RE;
    logic [AW-1:0] Mem_A;
    logic [DW-1:0] Mem_WD, Mem_RD;
    logic [1:0]    Last_grant;
`ifdef DMEM_ARB_STATS_EN
    logic          Stats_clr;
    logic [15:0]   Cnt0, Cnt1, Cnt_wait1;
`endif

    int checks   = 0;
    int failures = 0;

    // Environment memory (acts as DataMEM) and reference model state.
    logic [DW-1:0] memArr [256];
    logic [DW-1:0] refMem [256];
    int            waitCount;
    logic [DW-1:0] expRd0, expRd1;
    logic          expRv0, expRv1;
    logic [1:0]    expLast;
    logic          mG0, mG1;
    logic          obsG1, obsStall0;

    // Random-phase requester state.
    logic          rq0, rw0, rq1, rw1, pend0, pend1;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0v, rd1v;

    always #5 Clk = ~Clk;

    assign Mem_RD = memArr[Mem_A];

    dmem_arbiter #(
        .AW(AW), .DW(DW), .P0_MAX_BURST(P0_MAX_BURST)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wd0(Wd0),
        .Gnt0(Gnt0), .Stall0(Stall0), .Rvalid0(Rvalid0), .Rd0(Rd0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wd1(Wd1),
        .Gnt1(Gnt1), .Rvalid1(Rvalid1), .Rd1(Rd1),
        .Mem_WE(Mem_WE), .Mem_RE(Mem_RE), .Mem_A(Mem_A), .Mem_WD(Mem_WD),
        .Mem_RD(Mem_RD), .Last_grant(Last_grant)
`ifdef DMEM_ARB_STATS_EN
        , .Stats_clr(Stats_clr), .Cnt0(Cnt0), .Cnt1(Cnt1), .Cnt_wait1(Cnt_wait1)
`endif
    );

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive both requesters' inputs (called just after a falling edge).
    task automatic applyStimulus(input logic q0, input logic w0, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0, input logic q1, input logic w1,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        Req0 = q0; We0 = w0; Addr0 = a0; Wd0 = d0;
        Req1 = q1; We1 = w1; Addr1 = a1; Wd1 = d1;
    endtask

    // Model is returned to its reset state.
    task automatic modelReset();
        waitCount = 0;
        expRd0 = '0; expRd1 = '0;
        expRv0 = 1'b0; expRv1 = 1'b0;
        expLast = 2'b00;
    endtask

    // One full clock cycle starting at a falling edge with inputs applied:
    // check the combinational outputs against the model, let the edge happen,
    // update the model and environment memory, then check registered outputs.
    task automatic runCycle();
        logic g0, g1, weS;
        logic [AW-1:0] aS, expA;
        logic [DW-1:0] wdS, expWd;
        logic expWe, expRe;
        #1;
        g1 = Req1 && (!Req0 || (waitCount >= P0_MAX_BURST));
        g0 = Req0 && !g1;
        expA = g1 ? Addr1 : (g0 ? Addr0 : '0);
        expWd = g1 ? Wd1 : (g0 ? Wd0 : '0);
        expWe = (g1 && We1) || (g0 && We0);
        expRe = (g1 && !We1) || (g0 && !We0);
        checkOutput("gnt0", 16'(Gnt0), 16'(g0));
        checkOutput("gnt1", 16'(Gnt1), 16'(g1));
        checkOutput("stall0", 16'(Stall0), 16'(Req0 && !g0));
        checkOutput("mem_we", 16'(Mem_WE), 16'(expWe));
        checkOutput("mem_re", 16'(Mem_RE), 16'(expRe));
        checkOutput("mem_a", 16'(Mem_A), 16'(expA));
        checkOutput("mem_wd", 16'(Mem_WD), 16'(expWd));
        obsG1 = Gnt1;
        obsStall0 = Stall0;
        weS = Mem_WE; aS = Mem_A; wdS = Mem_WD;
        mG0 = g0; mG1 = g1;
        @(posedge Clk);
        if (weS) memArr[aS] <= wdS;
        expRv0 = g0 && !We0;
        expRv1 = g1 && !We1;
        if (g0 && We0) refMem[Addr0] = Wd0;
        if (g1 && We1) refMem[Addr1] = Wd1;
        if (expRv0) expRd0 = refMem[Addr0];
        if (expRv1) expRd1 = refMem[Addr1];
        if (g1 || !Req1) waitCount = 0;
        else if (waitCount < P0_MAX_BURST) waitCount++;
        expLast = g0 ? 2'b01 : (g1 ? 2'b10 : 2'b00);
        @(negedge Clk);
        checkOutput("rvalid0", 16'(Rvalid0), 16'(expRv0));
        checkOutput("rvalid1", 16'(Rvalid1), 16'(expRv1));
        checkOutput("rd0", 16'(Rd0), 16'(expRd0));
        checkOutput("rd1", 16'(Rd1), 16'(expRd1));
        checkOutput("last_grant", 16'(Last_grant), 16'(expLast));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            memArr[i] = 8'(i * 7 + 3);
            refMem[i] = 8'(i * 7 + 3);
        end
        modelReset();
        pend0 = 1'b0; pend1 = 1'b0;
        rq0 = 1'b0; rw0 = 1'b0; ra0 = '0; rd0v = '0;
        rq1 = 1'b0; rw1 = 1'b0; ra1 = '0; rd1v = '0;
`ifdef DMEM_ARB_STATS_EN
        Stats_clr = 1'b0;
`endif

        // Reset held with port 0 requesting a write: nothing may reach memory.
        Rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h50, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        checkOutput("rst_gnt0", 16'(Gnt0), 16'h0);
        checkOutput("rst_gnt1", 16'(Gnt1), 16'h0);
        checkOutput("rst_mem_we", 16'(Mem_WE), 16'h0);
        checkOutput("rst_mem_re", 16'(Mem_RE), 16'h0);
        checkOutput("rst_rd0", 16'(Rd0), 16'h0);
        checkOutput("rst_rvalid0", 16'(Rvalid0), 16'h0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) runCycle();
        checkOutput("idle_last_grant", 16'(Last_grant), 16'h0);

        // Port 0 write then read of the same address.
        applyStimulus(1'b1, 1'b1, 8'h50, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h00);
        runCycle();
        applyStimulus(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        runCycle();
        checkOutput("p0_rd", 16'(Rd0), 16'h00AA);
        checkOutput("p0_rvalid", 16'(Rvalid0), 16'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        runCycle();
        checkOutput("p0_rvalid_pulse", 16'(Rvalid0), 16'h0);

        // Port 1 alone; port 0 read-return untouched.
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'h3C);
        runCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00);
        runCycle();
        checkOutput("p1_rd", 16'(Rd1), 16'h003C);
        checkOutput("p1_rvalid", 16'(Rvalid1), 16'h1);
        checkOutput("p1_rd0_kept", 16'(Rd0), 16'h00AA);
        checkOutput("p1_rvalid0_quiet", 16'(Rvalid0), 16'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        runCycle();

        // Fairness: both held high, port 1 served every fifth cycle.
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 15; i++) begin
            runCycle();
            checkOutput("fair_gnt1", 16'(obsG1), 16'((i % 5) == 4));
            checkOutput("fair_stall0", 16'(obsStall0), 16'((i % 5) == 4));
        end

        // Cross-port coherence: port 1 read loses to port 0 write, then
        // returns the freshly written value.
        applyStimulus(1'b1, 1'b1, 8'h06, 8'h5A, 1'b1, 1'b0, 8'h06, 8'h00);
        runCycle();
        checkOutput("coh_first_gnt1", 16'(obsG1), 16'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h06, 8'h00);
        runCycle();
        checkOutput("coh_second_gnt1", 16'(obsG1), 16'h1);
        checkOutput("coh_rd1", 16'(Rd1), 16'h005A);

        // Reset mid-read with the starvation counter part-way up.
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        runCycle();
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        repeat (2) runCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        #1;
        checkOutput("mid_gnt1_before", 16'(Gnt1), 16'h1);
        #2;
        Rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_gnt1_in_rst", 16'(Gnt1), 16'h0);
        checkOutput("mid_mem_re_in_rst", 16'(Mem_RE), 16'h0);
`ifdef DMEM_ARB_STATS_EN
        checkOutput("mid_cnt1", Cnt1, 16'h0);
        checkOutput("mid_cnt0", Cnt0, 16'h0);
`endif
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("mid_rvalid1", 16'(Rvalid1), 16'h0);
        checkOutput("mid_rd1", 16'(Rd1), 16'h0);
        checkOutput("mid_last_grant", 16'(Last_grant), 16'h0);
        // Release between edges with both requesting; the full burst of four
        // port-0 grants shows the starvation count restarted from zero.
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        @(posedge Clk);
        #3;
        Rst_n = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkOutput("post_rst_gnt1", 16'(obsG1), 16'(i == 4));
        end

        // Randomized traffic obeying the hold-until-granted handshake.
        for (int i = 0; i < 400; i++) begin
            if (!pend0) begin
                rq0 = ($urandom_range(0, 3) != 0);
                rw0 = $urandom_range(0, 1) != 0;
                ra0 = 8'($urandom_range(0, 15));
                rd0v = 8'($urandom);
            end
            if (!pend1) begin
                rq1 = ($urandom_range(0, 2) == 0);
                rw1 = $urandom_range(0, 1) != 0;
                ra1 = 8'($urandom_range(0, 15));
                rd1v = 8'($urandom);
            end
            applyStimulus(rq0, rw0, ra0, rd0v, rq1, rw1, ra1, rd1v);
            runCycle();
            pend0 = rq0 && !mG0;
            pend1 = rq1 && !mG1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
